w_mem_loader: RTL and testbench
===============================

W_MEM_LOADER -- requirements
Module: w_mem_loader

Interface
REQ-001 SHALL have parameter ROW_BYTES, default 4, meaning bytes per weight-memory row (lanes per write).
REQ-002 SHALL have parameter NUM_BIT, default 8, meaning bits per byte lane.
REQ-003 SHALL have parameter ADDR_W, default 14, meaning weight-memory total word-address width.
REQ-004 SHALL have parameter ROWS_W, default 12, meaning width of the row-count field.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-008 SHALL have port abort  input  1  terminate the current load.
REQ-009 SHALL have port base_addr  input  ADDR_W  word address of the first row, sampled at start.
REQ-010 SHALL have port num_rows  input  ROWS_W  number of rows to load, sampled at start.
REQ-011 SHALL have port in_valid  input  1  upstream byte valid.
REQ-012 SHALL have port in_data  input  NUM_BIT signed  upstream weight byte.
REQ-013 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-014 SHALL have port wr_enable  output  1  weight-memory write strobe.
REQ-015 SHALL have port wr_addr  output  ADDR_W  weight-memory write address.
REQ-016 SHALL have port wr_data  output  ROWS_BYTES-element array of NUM_BIT signed  row data; element i is lane i.
REQ-017 SHALL have port busy  output  1  high in LOAD and FLUSH.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE; reset state IDLE.
REQ-020 SHALL, in IDLE on start with num_rows>0, latch base_addr and num_rows and go to LOAD; with num_rows=0, go to DONE.
REQ-021 SHALL ignore start in every state except IDLE.
REQ-022 SHALL drive in_ready=1 only in LOAD; a byte is accepted when in_valid & in_ready.
REQ-023 SHALL place accepted bytes into lanes 0..ROW_BYTES-1 in arrival order via a lane counter that wraps to 0 after lane ROW_BYTES-1.
REQ-024 SHALL, on acceptance of lane ROW_BYTES-1, assert wr_enable the next cycle for exactly one cycle with the completed row on wr_data (separate output register, so in_ready stays high: sustained 1 byte/cycle, no bubble).
REQ-025 SHALL set wr_addr = latched base_addr + row_index*ROW_BYTES, row_index starting at 0, arithmetic modulo 2^ADDR_W (wrap-around permitted, no error).
REQ-026 SHALL, on acceptance of the final lane of row num_rows-1, go to FLUSH; the final row's wr_enable occurs in the FLUSH cycle.
REQ-027 SHALL go FLUSH -> DONE -> IDLE unconditionally; done=1 only in DONE.
REQ-028 SHALL hold wr_enable=0, wr_addr and wr_data unchanged, whenever no row completes.
REQ-029 SHALL, on abort in LOAD, discard any partial row (no write), clear lane counter, go to IDLE without done; a row completed in the same cycle as abort is not written.
REQ-030 SHALL let abort in FLUSH or DONE have no effect; abort in IDLE is ignored.
REQ-031 SHALL not hold in_ready high while in_valid is low for any semantic; idle upstream cycles stall the lane counter only.

Reset
REQ-032 SHALL, on reset low, asynchronously force state IDLE, lane counter 0, row_index 0, in_ready 0, wr_enable 0, wr_addr 0, wr_data all 0, busy 0, done 0.
REQ-033 SHALL, on reset mid-load, lose the load entirely; no write or done after release until a new start.

Configuration
REQ-034 SHALL, with macro W_MEM_LOADER_CHECKSUM_EN defined, add output checksum (16 bits) = modulo-2^16 sum of all accepted bytes as unsigned, cleared on start, valid while done=1.
REQ-035 SHALL, without W_MEM_LOADER_CHECKSUM_EN, omit the checksum port and logic entirely.

Verification
REQ-036 SHALL cover: start, base_addr=0x0100, num_rows=2, bytes 0x01..0x08 back-to-back -> writes (0x0100,{01,02,03,04}) and (0x0104,{05,06,07,08}), done 2 cycles after byte 8.
REQ-037 SHALL cover: num_rows=0 start -> done next cycle, in_ready never high, no wr_enable.
REQ-038 SHALL cover: base_addr=0x3FFC, ADDR_W=14, num_rows=2 -> wr_addr 0x3FFC then 0x0000.
REQ-039 SHALL cover: abort after 6 of 8 bytes -> one write only (row 0), no done, IDLE; new start behaves normally.
REQ-040 SHALL cover: in_valid toggled 1/0 every cycle, start during LOAD -> correct rows, start ignored, throughput halved.
REQ-041 SHALL cover (CHECKSUM_EN): bytes 0xFF x8 -> checksum 0x07F8 at done.

Source files
------------

// File: rtl/w_mem_loader.sv
// Packs a stream of weight bytes into ROW_BYTES-wide rows and writes them at consecutive addresses; define W_MEM_LOADER_CHECKSUM_EN to add a byte checksum.
// A row is written one cycle after its last byte is accepted; in_ready is high throughout LOAD, so the loader sustains 1 byte/cycle.
module w_mem_loader #(
  parameter int ROW_BYTES = 4,
  parameter int NUM_BIT   = 8,
  parameter int ADDR_W    = 14,
  parameter int ROWS_W    = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ROWS_W-1:0]         num_rows,
  input  logic                      in_valid,
  input  logic signed [NUM_BIT-1:0] in_data,
  output logic                      in_ready,
  output logic                      wr_enable,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic signed [NUM_BIT-1:0] wr_data [ROW_BYTES],
  output logic                      busy,
  output logic                      done
`ifdef W_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]               checksum
`endif
);

  localparam int LANE_W = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [LANE_W-1:0]         r_lane;
  logic [ROWS_W-1:0]         r_row_idx;
  logic [ROWS_W-1:0]         r_num_rows;
  logic [ADDR_W-1:0]         r_base;
  logic [ADDR_W-1:0]         r_wr_addr;
  logic                      r_wr_en;
  logic signed [NUM_BIT-1:0] r_row_buf [ROW_BYTES];
  logic signed [NUM_BIT-1:0] r_wr_data [ROW_BYTES];
  logic                      w_take;
  logic                      w_last_lane;
  logic                      w_last_row;
  logic [ADDR_W-1:0]         w_row_off;

  // Abort wins over a same-cycle byte, so a row finishing under abort is never written.
  assign w_take      = in_valid && (r_state == S_LOAD) && !abort;
  assign w_last_lane = (r_lane == LANE_W'(ROW_BYTES - 1));
  assign w_last_row  = (r_row_idx == r_num_rows - ROWS_W'(1));
  assign w_row_off   = ADDR_W'(r_row_idx) * ADDR_W'(ROW_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (num_rows == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort)                                 w_state_nxt = S_IDLE;
        else if (w_take && w_last_lane && w_last_row) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane     <= '0;
      r_row_idx  <= '0;
      r_num_rows <= '0;
      r_base     <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      for (int i = 0; i < ROW_BYTES; i++) begin
        r_row_buf[i] <= '0;
        r_wr_data[i] <= '0;
      end
    end else begin
      r_wr_en <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_base     <= base_addr;
        r_num_rows <= num_rows;
        r_row_idx  <= '0;
        r_lane     <= '0;
      end else if (r_state == S_LOAD && abort) begin
        r_lane    <= '0;
        r_row_idx <= '0;
      end else if (w_take) begin
        r_row_buf[r_lane] <= in_data;
        if (w_last_lane) begin
          // The finished row moves to its own register so the next row can start filling immediately.
          r_lane    <= '0;
          r_row_idx <= r_row_idx + ROWS_W'(1);
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_base + w_row_off;
          for (int i = 0; i < ROW_BYTES; i++)
            r_wr_data[i] <= (i == ROW_BYTES - 1) ? in_data : r_row_buf[i];
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  assign wr_enable = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

`ifdef W_MEM_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_sum <= '0;
    else if (r_state == S_IDLE && start) r_sum <= '0;
    else if (w_take)                     r_sum <= r_sum + 16'($unsigned(in_data));
  end

  assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_w_mem_loader.sv
// Scoreboard bench for w_mem_loader: expected rows are queued as bytes are planned and popped when the DUT writes.
module tb_w_mem_loader;
  localparam int RB = 4;
  localparam int NB = 8;
  localparam int AW = 14;
  localparam int RW = 12;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [RW-1:0]        num_rows = '0;
  logic                 in_valid = 1'b0;
  logic signed [NB-1:0] in_data = '0;
  logic                 in_ready, wr_enable, busy, done;
  logic [AW-1:0]        wr_addr;
  logic signed [NB-1:0] wr_data [RB];
`ifdef W_MEM_LOADER_CHECKSUM_EN
  logic [15:0]          checksum;
`endif

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [RB*NB-1:0] d;
  } wr_t;

  logic [RB*NB-1:0] got_row;
  wr_t              exp_q[$];
  int               wr_cyc[$];
  logic [7:0]       bq[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, rdy_cnt = 0, wr_cnt = 0;

  w_mem_loader #(.ROW_BYTES(RB), .NUM_BIT(NB), .ADDR_W(AW), .ROWS_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_rows(num_rows),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
`ifdef W_MEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always_comb begin
    for (int i = 0; i < RB; i++) got_row[i*NB +: NB] = wr_data[i];
  end

  always @(negedge clk) begin
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (in_ready === 1'b1) rdy_cnt++;
    if (wr_enable === 1'b1) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, got_row);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || got_row !== e.d)
          $display("FAIL row_write: got addr=%h data=%h, required addr=%h data=%h", wr_addr, got_row, e.a, e.d);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [AW-1:0] a, input int r);
    wr_t e;
    e.a = a;
    for (int k = 0; k < RB; k++) e.d[k*NB +: NB] = bq[r*RB + k];
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [RW-1:0] n);
    start = 1'b1; base_addr = a; num_rows = n;
    step();
    start = 1'b0;
  endtask

  // Feeds bq; toggle inserts an idle cycle between bytes, start_at pulses a stray start with that byte.
  task automatic feed(input bit toggle, input int start_at);
    foreach (bq[i]) begin
      in_valid = 1'b1;
      in_data  = bq[i];
      if (i == start_at) begin
        start = 1'b1; base_addr = 14'h1234; num_rows = 12'd7;
      end
      step();
      start = 1'b0;
      if (toggle && i != bq.size() - 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, wr_enable, busy, done} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b, required 0000", {in_ready, wr_enable, busy, done});
    else n_pass++;
    n_checks++;
    if (wr_addr !== '0) $display("FAIL reset_addr: got %h, required 0", wr_addr);
    else n_pass++;
    n_checks++;
    if (got_row !== '0) $display("FAIL reset_data: got %h, required 0", got_row);
    else n_pass++;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int d0, sp;
    d0 = done_cnt;
    wr_cyc.delete();
    bq = {};
    for (int k = 1; k <= 8; k++) bq.push_back(8'(k));
    do_start(14'h0100, 12'd2);
    push_row(14'h0100, 0);
    push_row(14'h0104, 1);
    feed(1'b0, -1);
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL flush_state: got busy,done=%b, required 10", {busy, done});
    else n_pass++;
    step();
    n_checks++;
    if (done !== 1'b1) $display("FAIL done_after_byte8: got %b, required 1", done);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, done, in_ready} !== 3'b000) $display("FAIL idle_after_done: got %b, required 000", {busy, done, in_ready});
    else n_pass++;
    sp = (wr_cyc.size() == 2) ? wr_cyc[1] - wr_cyc[0] : -1;
    n_checks++;
    if (sp != 4) $display("FAIL row_spacing: got %0d cycles, required 4", sp);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL b2b_complete: got pending=%0d dones=%0d, required 0 and 1", exp_q.size(), done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_zero_rows();
    int r0, w0, d0;
    r0 = rdy_cnt; w0 = wr_cnt; d0 = done_cnt;
    do_start(14'h0055, 12'd0);
    n_checks++;
    if ({done, busy, in_ready} !== 3'b100) $display("FAIL zero_done_next: got %b, required 100", {done, busy, in_ready});
    else n_pass++;
    step(); step();
    n_checks++;
    if (rdy_cnt != r0 || wr_cnt != w0 || done_cnt - d0 != 1)
      $display("FAIL zero_rows: got ready=%0d writes=%0d dones=%0d, required 0 0 1", rdy_cnt - r0, wr_cnt - w0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int w0;
    w0 = wr_cnt;
    bq = {};
    for (int k = 0; k < 8; k++) bq.push_back(8'($urandom));
    do_start(14'h3FFC, 12'd2);
    push_row(14'h3FFC, 0);
    push_row(14'h0000, 1);
    feed(1'b0, -1);
    step(); step();
    n_checks++;
    if (exp_q.size() != 0 || wr_cnt - w0 != 2)
      $display("FAIL addr_wrap: got pending=%0d writes=%0d, required 0 and 2", exp_q.size(), wr_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_abort();
    int w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    bq = {};
    for (int k = 0; k < 6; k++) bq.push_back(8'(8'h10 + k));
    do_start(14'h0200, 12'd2);
    push_row(14'h0200, 0);
    feed(1'b0, -1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({busy, in_ready} !== 2'b00) $display("FAIL abort_to_idle: got %b, required 00", {busy, in_ready});
    else n_pass++;
    step(); step(); step();
    // Abort arriving together with the byte that would complete row 1.
    bq = {};
    for (int k = 0; k < 7; k++) bq.push_back(8'(8'h20 + k));
    do_start(14'h0300, 12'd2);
    push_row(14'h0300, 0);
    feed(1'b0, -1);
    in_valid = 1'b1; in_data = 8'h27; abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if (wr_cnt - w0 != 2 || done_cnt != d0 || exp_q.size() != 0)
      $display("FAIL abort_writes: got writes=%0d dones=%0d pending=%0d, required 2 0 0", wr_cnt - w0, done_cnt - d0, exp_q.size());
    else n_pass++;
    bq = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_start(14'h0010, 12'd1);
    push_row(14'h0010, 0);
    feed(1'b0, -1);
    step(); step();
    n_checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0)
      $display("FAIL restart_after_abort: got dones=%0d pending=%0d, required 1 0", done_cnt - d0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_toggle();
    int d0;
    bit ok;
    d0 = done_cnt;
    wr_cyc.delete();
    bq = {};
    for (int k = 0; k < 12; k++) bq.push_back(8'($urandom));
    do_start(14'h0040, 12'd3);
    push_row(14'h0040, 0);
    push_row(14'h0044, 1);
    push_row(14'h0048, 2);
    feed(1'b1, 5);
    step(); step();
    ok = (wr_cyc.size() == 3) && (wr_cyc[1] - wr_cyc[0] == 8) && (wr_cyc[2] - wr_cyc[1] == 8);
    n_checks++;
    if (!ok) $display("FAIL half_rate_spacing: got %0d writes, required 3 writes 8 cycles apart", wr_cyc.size());
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL toggle_complete: got pending=%0d dones=%0d, required 0 1", exp_q.size(), done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    int w0, d0, r0;
    w0 = wr_cnt; d0 = done_cnt;
    bq = {};
    for (int k = 0; k < 5; k++) bq.push_back(8'(8'h60 + k));
    do_start(14'h0080, 12'd2);
    push_row(14'h0080, 0);
    feed(1'b0, -1);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, wr_enable, busy, done} !== 4'b0000 || wr_addr !== '0 || got_row !== '0)
      $display("FAIL midload_reset: got ctrl=%b addr=%h data=%h, required all 0", {in_ready, wr_enable, busy, done}, wr_addr, got_row);
    else n_pass++;
    step();
    reset = 1'b1;
    r0 = rdy_cnt;
    in_valid = 1'b1; in_data = 8'h5A;
    step(); step(); step(); step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (wr_cnt - w0 != 1 || done_cnt != d0 || rdy_cnt != r0 || exp_q.size() != 0)
      $display("FAIL after_reset_quiet: got writes=%0d dones=%0d ready=%0d, required 1 0 0", wr_cnt - w0, done_cnt - d0, rdy_cnt - r0);
    else n_pass++;
  endtask

`ifdef W_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq = {};
    for (int k = 0; k < 8; k++) bq.push_back(8'hFF);
    do_start(14'h0000, 12'd2);
    push_row(14'h0000, 0);
    push_row(14'h0004, 1);
    feed(1'b0, -1);
    step();
    n_checks++;
    if (done !== 1'b1 || checksum !== 16'h07F8)
      $display("FAIL checksum: got done=%b sum=%h, required 1 07f8", done, checksum);
    else n_pass++;
    step();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_zero_rows();
    test_addr_wrap();
    test_abort();
    test_toggle();
    test_reset_midload();
`ifdef W_MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
